// File: rtl/mppt_po_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mppt_po_controller
//  Description : Perturb-and-observe maximum power point tracker. Accepts a
//                panel voltage/current sample, computes power, steps the
//                converter duty towards higher power and drives a 256-clock
//                PWM gate signal from the duty command.
//  Revision    : 1.0 - initial release
// ============================================================================
module mppt_po_controller #(
    parameter int STEP      = 4,
    parameter int DUTY_MIN  = 16,
    parameter int DUTY_MAX  = 240,
    parameter int DUTY_INIT = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  v_in,
    input  logic [7:0]  i_in,
    input  logic        track_en,
    output logic        s_ready,
    output logic [15:0] p_out,
    output logic        p_valid,
    output logic [7:0]  duty,
    output logic        dir,
    output logic        pwm
);

    // Limits widened to 9 bits so the step arithmetic can overflow 255
    // without wrapping before it is saturated.
    localparam logic [8:0] c_step_w  = 9'(STEP);
    localparam logic [8:0] c_min_w   = 9'(DUTY_MIN);
    localparam logic [8:0] c_max_w   = 9'(DUTY_MAX);
    localparam logic [7:0] c_min     = 8'(DUTY_MIN);
    localparam logic [7:0] c_max     = 8'(DUTY_MAX);
    localparam logic [7:0] c_init    = 8'(DUTY_INIT);
    localparam logic [7:0] c_cnt_top = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t      r_state;

    // Captured sample
    logic [7:0]  r_v;
    logic [7:0]  r_i;

    // Power path
    logic [15:0] r_p_out;
    logic [15:0] r_p_prev;
    logic        r_p_valid;
    logic        r_first;

    // Tracking state
    logic        r_s_ready;
    logic        r_dir;
    logic [7:0]  r_duty;

    // PWM generator
    logic [7:0]  r_cnt;
    logic [7:0]  r_duty_active;
    logic        r_pwm;

    // Decision path
    logic [15:0] w_product;
    logic        w_dir_pert;
    logic [8:0]  w_duty_ext;
    logic [8:0]  w_duty_sum;
    logic [7:0]  w_duty_new;
    logic        w_dir_new;

    // Full-width unsigned product of the captured sample.
    assign w_product = {8'd0, r_v} * {8'd0, r_i};

    // Perturb decision: direction, stepped duty with saturation, and the
    // direction forced back to the interior when a limit is reached.
    always_comb begin
        w_dir_pert = r_dir;
        w_duty_ext = {1'b0, r_duty};
        w_duty_sum = w_duty_ext;
        w_duty_new = r_duty;
        w_dir_new  = r_dir;

        // Power dropped since the previous sample: reverse the perturbation.
        // The very first sample has nothing to compare against.
        if (!r_first && (r_p_out < r_p_prev)) begin
            w_dir_pert = ~r_dir;
        end

        if (w_dir_pert) begin
            w_duty_sum = w_duty_ext + c_step_w;
        end else if (w_duty_ext >= c_step_w) begin
            w_duty_sum = w_duty_ext - c_step_w;
        end else begin
            w_duty_sum = 9'd0;
        end

        if (w_duty_sum > c_max_w) begin
            w_duty_new = c_max;
        end else if (w_duty_sum < c_min_w) begin
            w_duty_new = c_min;
        end else begin
            w_duty_new = w_duty_sum[7:0];
        end

        w_dir_new = w_dir_pert;
        if (w_duty_new == c_max) begin
            w_dir_new = 1'b0;
        end else if (w_duty_new == c_min) begin
            w_dir_new = 1'b1;
        end
    end

    // Sample handshake, power computation and duty update sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b1;
            r_v       <= 8'd0;
            r_i       <= 8'd0;
            r_p_out   <= 16'd0;
            r_p_valid <= 1'b0;
            r_p_prev  <= 16'd0;
            r_first   <= 1'b1;
            r_dir     <= 1'b1;
            r_duty    <= c_init;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_p_valid <= 1'b0;
                    if (s_valid && r_s_ready) begin
                        r_v       <= v_in;
                        r_i       <= i_in;
                        r_s_ready <= 1'b0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_p_out   <= w_product;
                    r_p_valid <= 1'b1;
                    r_state   <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_p_valid <= 1'b0;
                    r_p_prev  <= r_p_out;
                    r_first   <= 1'b0;
                    if (track_en) begin
                        r_dir  <= w_dir_new;
                        r_duty <= w_duty_new;
                    end
                    r_s_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_p_valid <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running PWM: duty only takes effect at a period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 8'd0;
            r_duty_active <= c_init;
            r_pwm         <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == c_cnt_top) begin
                r_duty_active <= r_duty;
            end
            r_pwm <= (r_cnt < r_duty_active);
        end
    end

    assign s_ready = r_s_ready;
    assign p_out   = r_p_out;
    assign p_valid = r_p_valid;
    assign duty    = r_duty;
    assign dir     = r_dir;
    assign pwm     = r_pwm;

endmodule
`default_nettype wire
